// File: rtl/synth_pkg.sv
// Shared constants, note increment table and FSM encoding for the
// note-to-pitch front end of the DDS voice.
package synth_pkg;

    localparam int FS      = 48000;
    localparam int OCT_TOP = 10;

    // Phase increments for MIDI notes 120..131 at FS with a 32-bit accumulator
    localparam logic [31:0] NOTE_INC_TABLE [12] = '{
        32'd749115498,
        32'd793660223,
        32'd840853716,
        32'd890853480,
        32'd943826385,
        32'd999949222,
        32'd1059409297,
        32'd1122405052,
        32'd1189146729,
        32'd1259857073,
        32'd1334772074,
        32'd1414141751
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_LOOKUP
    } state_e;

endpackage

// File: rtl/glide_slew.sv
// Holds target and output increment; slews phase_inc toward target on
// each tick by an arithmetic-shifted fraction of the remaining distance.
module glide_slew #(
    parameter int W      = 32,
    parameter int RATE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              load,
    input  logic              jump,
    input  logic [W-1:0]      target,
    input  logic [RATE_W-1:0] rate,
    output logic [W-1:0]      phase_inc,
    output logic              settled
);

    localparam logic signed [W:0] ONE = 1;

    logic [W-1:0]      target_q;
    logic [W-1:0]      phase_q;
    logic [W-1:0]      phase_d;
    logic signed [W:0] diff;
    logic signed [W:0] step;

    always_comb begin
        diff = $signed({1'b0, target_q}) - $signed({1'b0, phase_q});
        step = diff >>> rate;
        // Minimum step of one LSB guarantees the glide always lands
        if (step == '0 && diff != '0) begin
            step = diff[W] ? '1 : ONE;
        end
        phase_d = phase_q;
        if (jump) begin
            phase_d = target;
        end else if (tick) begin
            if (rate == '0) begin
                phase_d = target_q;
            end else begin
                phase_d = phase_q + step[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q <= '0;
            phase_q  <= '0;
        end else begin
            phase_q <= phase_d;
            if (load) begin
                target_q <= target;
            end
        end
    end

    assign phase_inc = phase_q;
    assign settled   = (phase_q == target_q);

endmodule

// File: rtl/note_to_phase_inc.sv
// Note event front end: splits the note into octave/semitone by repeated
// subtraction, scales the top-octave increment and feeds the glide stage.
module note_to_phase_inc
    import synth_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int RATE_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 note_valid,
    output logic                 note_ready,
    input  logic [6:0]           note,
    input  logic                 note_on,
    input  logic [RATE_W-1:0]    glide_rate,
    output logic [ACC_WIDTH-1:0] phase_inc,
    output logic                 gate,
    output logic                 settled
);

    if (ACC_WIDTH > 32) begin : g_bad_width
        $error("ACC_WIDTH must not exceed 32");
    end

    state_e               state_q;
    logic [6:0]           rem_q;
    logic [3:0]           oct_q;
    logic                 legato_q;
    logic                 gate_q;
    logic                 accept;
    logic                 load;
    logic                 jump;
    logic [31:0]          entry;
    logic [31:0]          shifted;
    logic [ACC_WIDTH-1:0] target_new;

    assign note_ready = (state_q == ST_IDLE);
    assign accept     = note_valid && note_ready;
    assign load       = (state_q == ST_LOOKUP);
    assign jump       = load && !legato_q;
    assign entry      = NOTE_INC_TABLE[rem_q[3:0]];
    assign shifted    = (entry >> (4'(OCT_TOP) - oct_q)) >> (32 - ACC_WIDTH);
    assign target_new = shifted[ACC_WIDTH-1:0];
    assign gate       = gate_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            oct_q    <= '0;
            legato_q <= 1'b0;
            gate_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (note_on) begin
                            rem_q    <= note;
                            oct_q    <= '0;
                            legato_q <= gate_q;
                            state_q  <= ST_DIVIDE;
                        end else begin
                            gate_q <= 1'b0;
                        end
                    end
                end
                ST_DIVIDE: begin
                    if (rem_q >= 7'd12) begin
                        rem_q <= rem_q - 7'd12;
                        oct_q <= oct_q + 4'd1;
                    end else begin
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    gate_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    glide_slew #(
        .W      (ACC_WIDTH),
        .RATE_W (RATE_W)
    ) u_slew (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .load      (load),
        .jump      (jump),
        .target    (target_new),
        .rate      (glide_rate),
        .phase_inc (phase_inc),
        .settled   (settled)
    );

endmodule

// File: tb/tb_note_to_phase_inc.sv
// Bench for note_to_phase_inc: vector table, directed glide/reset
// sequences and random traffic against a cycle-level pitch model.
module tb_note_to_phase_inc;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        tick       = 1'b0;
    logic        note_valid = 1'b0;
    logic        note_on    = 1'b0;
    logic [6:0]  note       = '0;
    logic [3:0]  glide_rate = '0;
    logic        note_ready;
    logic        gate;
    logic        settled;
    logic [31:0] phase_inc;

    int checks = 0;
    int errors = 0;

    longint m_phase, m_target, m_pend;
    int     m_cnt;
    bit     m_gate, m_leg;

    always #5 clk = ~clk;

    note_to_phase_inc #(
        .ACC_WIDTH (32),
        .RATE_W    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note       (note),
        .note_on    (note_on),
        .glide_rate (glide_rate),
        .phase_inc  (phase_inc),
        .gate       (gate),
        .settled    (settled)
    );

    function automatic longint note_value(input int n);
        int     oct = n / 12;
        int     k   = n % 12;
        real    f   = 440.0 * (2.0 ** ((120.0 + k - 69.0) / 12.0));
        longint top = longint'(f * 4294967296.0 / 48000.0);
        return top >> (10 - oct);
    endfunction

    function automatic longint glide(input longint p, input longint tg, input int r);
        longint d = tg - p;
        longint q, s;
        if (r == 0) return tg;
        q = longint'(1) << r;
        if (d >= 0) s = d / q;
        else s = -((-d + q - 1) / q);
        if (s == 0 && d != 0) s = (d > 0) ? 1 : -1;
        return p + s;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("phase_inc", longint'(phase_inc), m_phase);
        chk("gate", longint'(gate), longint'(m_gate));
        chk("settled", longint'(settled), longint'(m_phase == m_target));
        chk("note_ready", longint'(note_ready), longint'(m_cnt == 0));
    endtask

    task automatic model_edge(input bit t, input bit v, input int n, input bit on, input int r);
        bit rdy = (m_cnt == 0);
        if (m_cnt == 1 && !m_leg) m_phase = m_pend;
        else if (t) m_phase = glide(m_phase, m_target, r);
        if (m_cnt == 1) begin
            m_target = m_pend;
            m_gate   = 1'b1;
        end
        if (m_cnt != 0) m_cnt--;
        if (v && rdy) begin
            if (on) begin
                m_pend = note_value(n);
                m_leg  = m_gate;
                m_cnt  = n / 12 + 2;
            end else begin
                m_gate = 1'b0;
            end
        end
    endtask

    task automatic cyc(input bit t, input bit v, input int n, input bit on, input int r);
        tick       = t;
        note_valid = v;
        note       = 7'(n);
        note_on    = on;
        glide_rate = 4'(r);
        @(posedge clk);
        model_edge(t, v, n, on, r);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        tick       = 1'b0;
        note_valid = 1'b0;
        #1;
        m_phase  = 0;
        m_target = 0;
        m_gate   = 1'b0;
        m_cnt    = 0;
        m_leg    = 1'b0;
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_ready(input bit t, input int r, input int budget, output int lat);
        lat = 0;
        for (int i = 0; i < budget; i++) begin
            cyc(t, 0, 0, 0, r);
            lat++;
            if (note_ready) break;
        end
        if (!note_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_settled(input int period, input int r, input int budget);
        for (int i = 0; i < budget; i++) begin
            cyc((i % period) == 0, 0, 0, 0, r);
            if (settled) break;
        end
        if (!settled) chk("settle_timeout", 0, 1);
    endtask

    typedef struct {
        int     n;
        int     lat;
        longint inc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int     lat;
        longint prev, peak;
        bit     mono, over;

        vecs = '{
            '{0,   2,  731558},
            '{12,  3,  1463116},
            '{60,  7,  23409859},
            '{69,  7,  39370533},
            '{81,  8,  78741067},
            '{127, 12, 1122405052}
        };

        do_reset();
        chk("reset_phase", longint'(phase_inc), 0);
        chk("reset_settled", longint'(settled), 1);

        // First notes jump straight to pitch after oct+2 cycles
        foreach (vecs[i]) begin
            do_reset();
            cyc(1, 1, vecs[i].n, 1, 0);
            wait_ready(1, 0, 20, lat);
            chk("latency", lat, vecs[i].lat);
            chk("first_note_inc", longint'(phase_inc), vecs[i].inc);
            chk("first_note_gate", longint'(gate), 1);
        end

        // Legato upward glide 69 -> 81, rate 2, tick every 4 cycles
        do_reset();
        cyc(0, 1, 69, 1, 0);
        wait_ready(0, 0, 20, lat);
        cyc(0, 1, 81, 1, 2);
        wait_ready(0, 2, 20, lat);
        chk("legato_no_jump", longint'(phase_inc), 39370533);
        mono = 1'b1;
        over = 1'b0;
        prev = longint'(phase_inc);
        for (int i = 0; i < 40; i++) begin
            cyc((i % 4) == 0, 0, 0, 0, 2);
            if (longint'(phase_inc) < prev) mono = 1'b0;
            if (longint'(phase_inc) > 78741067) over = 1'b1;
            prev = longint'(phase_inc);
        end
        chk("glide_monotonic", longint'(mono), 1);
        chk("glide_no_overshoot", longint'(over), 0);
        chk("glide_moved", longint'(phase_inc > 39370533), 1);

        // Note-off mid-glide: gate drops, glide carries on
        cyc(0, 1, 5, 0, 2);
        chk("noteoff_gate", longint'(gate), 0);
        chk("noteoff_ready", longint'(note_ready), 1);
        wait_settled(4, 2, 1000);
        chk("glide_final", longint'(phase_inc), 78741067);

        // Non-legato after note-off: jump wins over a coincident tick
        cyc(1, 1, 69, 1, 4);
        wait_ready(1, 4, 20, lat);
        chk("jump_after_off", longint'(phase_inc), 39370533);
        chk("jump_settled", longint'(settled), 1);

        // Downward glide 81 -> 69 with the slowest rate, then faster
        cyc(0, 1, 81, 1, 0);
        wait_ready(0, 0, 20, lat);
        cyc(1, 0, 0, 0, 0);
        chk("at_81", longint'(phase_inc), 78741067);
        cyc(0, 1, 69, 1, 15);
        wait_ready(0, 15, 20, lat);
        peak = longint'(phase_inc);
        for (int i = 0; i < 300; i++) cyc(1, 0, 0, 0, 15);
        chk("slow_down_moved", longint'(phase_inc < peak), 1);
        mono = 1'b1;
        for (int i = 0; i < 500; i++) begin
            cyc(1, 0, 0, 0, 3);
            if (longint'(phase_inc) < 39370533) mono = 1'b0;
            if (settled) break;
        end
        chk("down_no_undershoot", longint'(mono), 1);
        chk("down_final", longint'(phase_inc), 39370533);

        // Asynchronous reset in the middle of a divide
        cyc(0, 1, 127, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("async_phase", longint'(phase_inc), 0);
        chk("async_gate", longint'(gate), 0);
        chk("async_settled", longint'(settled), 1);
        chk("async_ready", longint'(note_ready), 1);
        m_phase  = 0;
        m_target = 0;
        m_gate   = 1'b0;
        m_cnt    = 0;
        m_leg    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(0, 1, 69, 1, 3);
        wait_ready(0, 3, 20, lat);
        chk("post_reset_lat", lat, 7);
        chk("post_reset_jump", longint'(phase_inc), 39370533);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 1) == 1,
                $urandom_range(0, 9) < 3,
                int'($urandom_range(0, 127)),
                $urandom_range(0, 9) < 7,
                int'($urandom_range(0, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
